// File: rtl/pong_ball_ctrl.sv
// rtl/pong_ball_ctrl.sv - Pong ball motion, collision and scoring engine
// Optional build macro SPEED_UP_EN: each paddle hit raises speed by one, capped at MAX_SPEED.
module pong_ball_ctrl #(
    parameter int H_RES       = 640,
    parameter int TOP_WALL    = 24,
    parameter int BOT_WALL    = 476,
    parameter int BALL        = 8,
    parameter int L_FACE      = 38,
    parameter int R_FACE      = 602,
    parameter int SPEED       = 2,
    parameter int MAX_SPEED   = 6,
    parameter int STEP_DIV    = 416667,
    parameter int SERVE_STEPS = 120,
    parameter int WIN_SCORE   = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] l_top,
    input  logic [9:0] l_bot,
    input  logic [9:0] r_top,
    input  logic [9:0] r_bot,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       round_restart,
    output logic       paddle_hit,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);
    localparam int PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SW    = $clog2(SERVE_STEPS + 1);
    localparam int SPD_W = $clog2(((MAX_SPEED > SPEED) ? MAX_SPEED : SPEED) + 1);

    localparam logic [9:0] X_CTR  = 10'd316;
    localparam logic [9:0] Y_CTR  = 10'd236;
    localparam logic [9:0] HRES_W = 10'(H_RES);
    localparam logic [9:0] TOP_W  = 10'(TOP_WALL);
    localparam logic [9:0] BOT_W  = 10'(BOT_WALL);
    localparam logic [9:0] BALL_W = 10'(BALL);
    localparam logic [9:0] LF_W   = 10'(L_FACE);
    localparam logic [9:0] RF_W   = 10'(R_FACE);

    typedef enum logic [1:0] {SERVE, PLAY, SCORED, GAME_OVER} state_t;

    state_t           state;
    logic [PW-1:0]    presc;
    logic [SW-1:0]    serve_cnt;
    logic [SPD_W-1:0] speed;
    logic             dir_x;
    logic             dir_y;
    logic             step;
    logic [9:0]       spd;

    logic [9:0] nx;
    logic [9:0] ny;
    logic       ndx;
    logic       ndy;
    logic       hit;
    logic       miss;
    logic       l_ovl;
    logic       r_ovl;

    assign step = (presc == PW'(STEP_DIV - 1));
    assign spd  = 10'(speed);

    always_comb begin
        ny    = ball_y;
        ndy   = dir_y;
        nx    = ball_x;
        ndx   = dir_x;
        hit   = 1'b0;
        miss  = 1'b0;
        l_ovl = (ball_y + BALL_W > l_top) && (ball_y < l_bot);
        r_ovl = (ball_y + BALL_W > r_top) && (ball_y < r_bot);

        if (dir_y) begin
            if (ball_y + BALL_W + 10'd1 >= BOT_W) begin
                ny  = BOT_W - BALL_W;
                ndy = 1'b0;
            end else begin
                ny = ball_y + 10'd1;
            end
        end else begin
            if (ball_y <= TOP_W + 10'd1) begin
                ny  = TOP_W;
                ndy = 1'b1;
            end else begin
                ny = ball_y - 10'd1;
            end
        end

        if (!dir_x) begin
            if (ball_x >= LF_W && ball_x <= LF_W + spd && l_ovl) begin
                nx  = LF_W;
                ndx = 1'b1;
                hit = 1'b1;
            end else if (ball_x <= spd) begin
                miss = 1'b1;
            end else begin
                nx = ball_x - spd;
            end
        end else begin
            if (ball_x + BALL_W <= RF_W && ball_x + BALL_W + spd >= RF_W && r_ovl) begin
                nx  = RF_W - BALL_W;
                ndx = 1'b0;
                hit = 1'b1;
            end else if (ball_x + BALL_W + spd >= HRES_W) begin
                miss = 1'b1;
            end else begin
                nx = ball_x + spd;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= SERVE;
            presc         <= '0;
            serve_cnt     <= '0;
            speed         <= SPD_W'(SPEED);
            ball_x        <= X_CTR;
            ball_y        <= Y_CTR;
            dir_x         <= 1'b1;
            dir_y         <= 1'b1;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            round_restart <= 1'b0;
            paddle_hit    <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            presc         <= step ? '0 : presc + 1'b1;
            round_restart <= 1'b0;
            paddle_hit    <= 1'b0;
            case (state)
                SERVE: begin
                    if (step) begin
                        if (serve_cnt == SW'(SERVE_STEPS - 1)) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (step) begin
                        if (miss) begin
                            // dir_x already points at the conceding side, so it is kept
                            state         <= SCORED;
                            round_restart <= 1'b1;
                            speed         <= SPD_W'(SPEED);
                            ball_x        <= X_CTR;
                            ball_y        <= Y_CTR;
                            if (dir_x) score_l <= score_l + 4'd1;
                            else       score_r <= score_r + 4'd1;
                        end else begin
                            ball_x     <= nx;
                            ball_y     <= ny;
                            dir_x      <= ndx;
                            dir_y      <= ndy;
                            paddle_hit <= hit;
`ifdef SPEED_UP_EN
                            if (hit && speed < SPD_W'(MAX_SPEED)) speed <= speed + 1'b1;
`endif
                        end
                    end
                end
                SCORED: begin
                    if (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE)) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= SERVE;
                    end
                end
                default: begin
                    game_over <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb/tb_pong_ball_ctrl.sv - directed checks of ball motion, bounces, scoring and game over
module tb_pong_ball_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] l_top = '0, l_bot = '0, r_top = '0, r_bot = '0;
    logic [9:0] ball_x, ball_y;
    logic       round_restart, paddle_hit, game_over;
    logic [3:0] score_l, score_r;

    pong_ball_ctrl #(.STEP_DIV(4), .SERVE_STEPS(2)) dut (
        .clock(clock), .reset(reset),
        .l_top(l_top), .l_bot(l_bot), .r_top(r_top), .r_bot(r_bot),
        .ball_x(ball_x), .ball_y(ball_y),
        .round_restart(round_restart), .paddle_hit(paddle_hit),
        .score_l(score_l), .score_r(score_r), .game_over(game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        int k;
        int lt, lb, rt, rb;
        int x, y, hit, sl, rr;
    } vec_t;

    vec_t vec[18];
    int   checks = 0;
    int   errors = 0;
    int   now = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Each tick lands 1 time unit after a rising edge; now counts edges since reset release.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        now += n;
        #1;
    endtask

    task automatic go_step(input int k);
        tick(4 * k - now);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        now = 0;
    endtask

    task automatic wait_restart(input string name, input int limit);
        int n;
        n = 0;
        while (round_restart !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk(name, (n < limit) ? 1 : 0, 1);
    endtask

    initial begin
        vec[0]  = '{1,   270, 320, 350, 400, 316, 236, 0, 0, 0};
        vec[1]  = '{2,   270, 320, 350, 400, 316, 236, 0, 0, 0};
        vec[2]  = '{3,   270, 320, 350, 400, 318, 237, 0, 0, 0};
        vec[3]  = '{140, 270, 320, 350, 400, 592, 374, 0, 0, 0};
        vec[4]  = '{141, 270, 320, 350, 400, 594, 375, 1, 0, 0};
        vec[5]  = '{142, 270, 320, 200, 240, 592, 376, 0, 0, 0};
        vec[6]  = '{233, 270, 320, 200, 240, 410, 467, 0, 0, 0};
        vec[7]  = '{234, 270, 320, 200, 240, 408, 468, 0, 0, 0};
        vec[8]  = '{235, 270, 320, 200, 240, 406, 467, 0, 0, 0};
        vec[9]  = '{418, 270, 320, 200, 240, 40,  284, 0, 0, 0};
        vec[10] = '{419, 270, 320, 200, 240, 38,  283, 1, 0, 0};
        vec[11] = '{420, 0,   0,   200, 240, 40,  282, 0, 0, 0};
        vec[12] = '{677, 0,   0,   200, 240, 554, 25,  0, 0, 0};
        vec[13] = '{678, 0,   0,   200, 240, 556, 24,  0, 0, 0};
        vec[14] = '{679, 0,   0,   200, 240, 558, 25,  0, 0, 0};
        vec[15] = '{715, 0,   0,   200, 240, 630, 61,  0, 0, 0};
        vec[16] = '{716, 0,   0,   200, 240, 316, 236, 0, 1, 1};
        vec[17] = '{719, 0,   0,   200, 240, 318, 237, 0, 1, 0};

        // Reset state
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_x", ball_x, 316);
        chk("reset_y", ball_y, 236);
        chk("reset_score_l", score_l, 0);
        chk("reset_score_r", score_r, 0);
        chk("reset_game_over", game_over, 0);
        chk("reset_restart", round_restart, 0);
        chk("reset_hit", paddle_hit, 0);

        // Rally: right hit, bottom bounce, left hit, top bounce, right miss
        release_reset();
        for (int i = 0; i < 18; i++) begin
            l_top = 10'(vec[i].lt); l_bot = 10'(vec[i].lb);
            r_top = 10'(vec[i].rt); r_bot = 10'(vec[i].rb);
            go_step(vec[i].k);
            chk($sformatf("vec%0d_x", i), ball_x, vec[i].x);
            chk($sformatf("vec%0d_y", i), ball_y, vec[i].y);
            chk($sformatf("vec%0d_hit", i), paddle_hit, vec[i].hit);
            chk($sformatf("vec%0d_score_l", i), score_l, vec[i].sl);
            chk($sformatf("vec%0d_restart", i), round_restart, vec[i].rr);
            if (vec[i].hit == 1) begin
                tick(1);
                chk($sformatf("vec%0d_hit_width", i), paddle_hit, 0);
            end
            if (vec[i].rr == 1) begin
                tick(1);
                chk($sformatf("vec%0d_restart_width", i), round_restart, 0);
                chk($sformatf("vec%0d_score_r", i), score_r, 0);
            end
        end

        // Left keeps scoring until the game ends
        l_top = '0; l_bot = '0; r_top = '0; r_bot = '0;
        for (int s = 2; s <= 9; s++) begin
            wait_restart($sformatf("point%0d_seen", s), 2000);
            chk($sformatf("point%0d_score_l", s), score_l, s);
            tick(1);
        end
        chk("win_game_over", game_over, 1);
        chk("win_ball_x", ball_x, 316);
        chk("win_ball_y", ball_y, 236);
        begin
            int bad;
            bad = 0;
            for (int c = 0; c < 4000; c++) begin
                tick(1);
                if (ball_x !== 10'd316 || ball_y !== 10'd236 || game_over !== 1'b1 ||
                    score_l !== 4'd9 || score_r !== 4'd0 || round_restart !== 1'b0)
                    bad++;
            end
            chk("game_over_hold_bad_cycles", bad, 0);
        end

        // Reset clears game over
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_go_game_over", game_over, 0);
        chk("rst_go_score_l", score_l, 0);
        chk("rst_go_x", ball_x, 316);

        // Left miss: right paddle spans the field, left paddle absent
        l_top = '0;     l_bot = '0;
        r_top = 10'd24; r_bot = 10'd476;
        release_reset();
        go_step(141);
        chk("lm_right_hit_x", ball_x, 594);
        chk("lm_right_hit", paddle_hit, 1);
        go_step(437);
        chk("lm_before_x", ball_x, 2);
        chk("lm_before_score_r", score_r, 0);
        go_step(438);
        chk("lm_restart", round_restart, 1);
        chk("lm_score_r", score_r, 1);
        chk("lm_score_l", score_l, 0);
        chk("lm_centre_x", ball_x, 316);
        chk("lm_centre_y", ball_y, 236);
        tick(1);
        chk("lm_restart_width", round_restart, 0);
        go_step(440);
        chk("lm_serve_hold_x", ball_x, 316);
        go_step(441);
        chk("lm_serve_x", ball_x, 314);
        chk("lm_serve_y", ball_y, 235);
        chk("lm_game_over", game_over, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
- Ball motion, wall/paddle collision and scoring engine for the Pong design.
- Sits directly downstream of the two paddle movement blocks: consumes each paddle's top/bottom Y coordinates, produces the ball position for the VGA renderer, and produces the round-restart pulse that re-centres the paddles.
- Holds the score and the game-over state.

Parameters:
- H_RES, 640, horizontal field width in pixels
- TOP_WALL, 24, first playable row; ball_y never < TOP_WALL
- BOT_WALL, 476, last playable row + 1; ball_y+BALL never > BOT_WALL
- BALL, 8, ball side length in pixels
- L_FACE, 38, x of left paddle hitting face (paddle occupies 30..37)
- R_FACE, 602, x of right paddle hitting face (paddle occupies 602..609)
- SPEED, 2, horizontal pixels per step (vertical step fixed at 1)
- MAX_SPEED, 6, speed ceiling (SPEED_UP_EN only)
- STEP_DIV, 416667, clock cycles per motion step (~120 Hz at 50 MHz)
- SERVE_STEPS, 120, steps ball is held at centre before each serve
- WIN_SCORE, 9, score that ends the game

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- l_top  in  10  left paddle top Y
- l_bot  in  10  left paddle bottom Y
- r_top  in  10  right paddle top Y
- r_bot  in  10  right paddle bottom Y
- ball_x  out  10  ball left edge X
- ball_y  out  10  ball top edge Y
- round_restart  out  1  one-cycle pulse after a point; drives paddle re-centre input
- paddle_hit  out  1  one-cycle pulse on any paddle bounce
- score_l  out  4  left player score
- score_r  out  4  right player score
- game_over  out  1  high once either score reaches WIN_SCORE

Behaviour:
- Reset (reset==0 at posedge): ball_x=316, ball_y=236, dir_x=1 (right), dir_y=1 (down), speed=SPEED, scores 0, round_restart=0, paddle_hit=0, game_over=0, prescaler=0, serve counter=0, state=SERVE. Reset overrides everything, including mid-SCORED or GAME_OVER.
- Prescaler: counts 0..STEP_DIV-1 and wraps; step strobe is asserted for the one cycle it equals STEP_DIV-1. Runs in all states.
- States:
  - SERVE: ball held at (316,236); on each step, serve counter increments; when it reaches SERVE_STEPS-1 on a step, counter is cleared -> PLAY.
  - PLAY: ball updates only on the step strobe, per the rules below.
  - SCORED: lasts exactly one cycle. round_restart=1; winning score increments; speed reloads to SPEED; ball returns to centre. dir_x points toward the conceding player. If the new score equals WIN_SCORE -> GAME_OVER, else -> SERVE.
  - GAME_OVER: ball held at centre, game_over=1, scores frozen; exits only via reset.
- PLAY step, vertical:
  - dir_y=1 and ball_y+BALL+1 >= BOT_WALL: ball_y=BOT_WALL-BALL, dir_y=0.
  - dir_y=0 and ball_y <= TOP_WALL+1 (strict test ball_y-1 <= TOP_WALL): ball_y=TOP_WALL, dir_y=1.
  - Otherwise ball_y moves ±1.
- PLAY step, horizontal left (dir_x=0):
  - Hit: ball_x >= L_FACE, ball_x <= L_FACE+speed and overlap (ball_y+BALL > l_top and ball_y < l_bot). Then ball_x=L_FACE, dir_x=1, paddle_hit pulse.
  - Miss: otherwise, if ball_x <= speed, -> SCORED, right scores.
  - Otherwise ball_x -= speed.
- PLAY step, horizontal right (dir_x=1):
  - Hit: ball_x+BALL <= R_FACE, ball_x+BALL+speed >= R_FACE and overlap with r_top/r_bot. Then ball_x=R_FACE-BALL, dir_x=0, paddle_hit pulse.
  - Miss: otherwise, if ball_x+BALL+speed >= H_RES, -> SCORED, left scores.
  - Otherwise ball_x += speed.
- Overlap comparisons are strict, so a corner touch is not a hit.
- Simultaneous events: a vertical wall bounce and a paddle bounce on the same step are both applied. A vertical bounce on a scoring step is discarded because the ball recentres.
- All arithmetic is 10-bit unsigned. Subtractions are guarded by the comparisons above, so no underflow or wrap is possible.
- Paddle inputs are sampled only on step cycles.
- Pulses (round_restart, paddle_hit) are registered, high for exactly one clock.

Optional Feature:
- Macro: SPEED_UP_EN.
- Defined: each paddle hit sets speed=min(speed+1, MAX_SPEED), effective from the next step; speed reloads to SPEED in SCORED.
- Undefined: speed is constant SPEED and MAX_SPEED is unused.

Test Plan:
- Reset: hold reset=0 for 3 cycles -> ball (316,236), scores 0, game_over 0, all pulses 0; with STEP_DIV=4, SERVE_STEPS=2 the ball first moves 12 cycles after release, to (318,237).
- Bottom wall: ball at y=467 moving down -> next step y=468, following step dir_y=0, y=467.
- Left paddle hit: l_top=200, l_bot=240, ball at x=39, y=210, dir_x=0 -> x=38, dir_x=1, paddle_hit pulse 1 cycle.
- Left miss: l_top=300, l_bot=340, ball x=2, y=210, dir_x=0 -> SCORED: score_r 0->1, round_restart 1 cycle, ball (316,236), dir_x=0, SERVE.
- Game over: score_l=8, ball reaches x=630 moving right with no right paddle overlap -> score_l=9, game_over=1, ball stays at centre for 1000 steps; reset clears it.
- SPEED_UP_EN: 5 consecutive paddle hits -> horizontal step sizes 3,4,5,6,6; after a point, step size is back to 2.
